// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the RISC CPU slice: opcodes, controller states,
// and the memory responder's widths, I/O address and state encoding.
package cpu_mem_responder_pkg;

    typedef enum logic [2:0] {
        OP_HLT,
        OP_SKZ,
        OP_ADD,
        OP_AND,
        OP_XOR,
        OP_LDA,
        OP_STO,
        OP_JMP
    } opcode_t;

    typedef enum logic [2:0] {
        CTL_INST_ADDR,
        CTL_INST_FETCH,
        CTL_INST_LOAD,
        CTL_IDLE,
        CTL_OP_ADDR,
        CTL_OP_FETCH,
        CTL_ALU_OP,
        CTL_STORE
    } ctl_state_t;

    localparam int RSP_AW    = 5;
    localparam int RSP_DW    = 8;
    localparam int RSP_DEPTH = 32;

    localparam logic [RSP_AW-1:0] RSP_IO_ADDR = 5'h1F;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_READ,
        RSP_WRITE
    } rsp_state_t;

endpackage

// File: rtl/cpu_mem_responder_mem_array_1r1w.sv
// Word RAM: synchronous single write port, combinational read port.
// Contents are never reset.
module mem_array_1r1w #(
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: registered reads, edge-committed
// writes, one memory-mapped output register and a RAM preload port.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int            AW      = RSP_AW,
    parameter int            DW      = RSP_DW,
    parameter int            DEPTH   = RSP_DEPTH,
    parameter logic [AW-1:0] IO_ADDR = RSP_IO_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          wr,
    input  logic          data_e,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic [DW-1:0] io_out,
    output logic          io_strobe,
    output logic          prot_err,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_stall
);

    rsp_state_t state_q;
    rsp_state_t state_d;

    logic          is_io;
    logic          rd_ok;
    logic          cpu_io_we;
    logic          cpu_mem_we;
    logic          ld_ok;
    logic          ld_io_we;
    logic          ld_mem_we;
    logic          viol;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // A write always wins over a read; the read is simply dropped.
    always_comb begin
        state_d = RSP_IDLE;
        priority case (1'b1)
            wr:      state_d = RSP_WRITE;
            rd:      state_d = RSP_READ;
            default: state_d = RSP_IDLE;
        endcase
    end

    always_comb begin
        is_io      = (addr == IO_ADDR);
        rd_ok      = rd & ~wr;
        cpu_io_we  = wr & data_e & is_io;
        cpu_mem_we = wr & data_e & ~is_io;
        viol       = (wr ^ data_e) | (rd & wr);
        ld_stall   = ld_we & (rd | wr | data_e);
        ld_ok      = ld_we & ~ld_stall;
        ld_io_we   = ld_ok & (ld_addr == IO_ADDR);
        ld_mem_we  = ld_ok & (ld_addr != IO_ADDR);
    end

    // The loader only gets the port when the CPU bus is quiet.
    always_comb begin
        mem_we    = cpu_mem_we | ld_mem_we;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (cpu_mem_we) begin
            mem_waddr = addr;
            mem_wdata = wdata;
        end
    end

    mem_array_1r1w #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RSP_IDLE;
            rdata     <= '0;
            io_out    <= '0;
            io_strobe <= 1'b0;
            prot_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            io_strobe <= cpu_io_we;
            if (rd_ok) begin
                rdata <= is_io ? io_out : mem_rdata;
            end
            if (cpu_io_we) begin
                io_out <= wdata;
            end else if (ld_io_we) begin
                io_out <= ld_data;
            end
            if (viol) begin
                prot_err <= 1'b1;
            end
        end
    end

    // READ is entered exactly on edges that sampled a clean read.
    assign rdata_valid = (state_q == RSP_READ);

endmodule
